// File: rtl/proc_seq.sv
// Program sequencer: replays a small instruction memory into the bus processor's
// w/F/Rx/Ry/din handshake, one instruction per Done, with a watchdog on WAIT.
module proc_seq #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prog_we,
  input  logic [AW-1:0]     prog_addr,
  input  logic [6+DATA_W-1:0] prog_wdata,
  input  logic [AW:0]       prog_len,
  input  logic              start,
  input  logic              abort,
  input  logic              done_in,
  output logic              w,
  output logic [1:0]        F,
  output logic [1:0]        Rx,
  output logic [1:0]        Ry,
  output logic [DATA_W-1:0] din,
  output logic              busy,
  output logic              finished,
  output logic              err_timeout,
  output logic [AW-1:0]     pc,
  output logic [2:0]        o_dbg_state
);

  localparam int IW = 6 + DATA_W;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [AW:0]   DEPTH_L   = (AW+1)'(DEPTH);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_ISSUE  = 3'd2,
    S_WAIT   = 3'd3,
    S_FINISH = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  state_t        r_state;
  logic [IW-1:0] r_mem [DEPTH];
  logic [IW-1:0] r_instr;
  logic [AW:0]   r_len;
  logic [TW-1:0] r_timer;
  logic          w_last;

  // Handshake: w is a one-cycle request carrying F/Rx/Ry/din; the processor
  // acknowledges with done_in, which is only honoured while in WAIT.
  assign w_last      = ({1'b0, pc} == (r_len - 1'b1));
  assign F           = r_instr[IW-1 -: 2];
  assign Rx          = r_instr[IW-3 -: 2];
  assign Ry          = r_instr[IW-5 -: 2];
  assign din         = r_instr[DATA_W-1:0];
  assign o_dbg_state = r_state;

  always_ff @(posedge clk) begin
    if (prog_we && !busy) begin
      r_mem[prog_addr] <= prog_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      pc          <= '0;
      r_timer     <= '0;
      r_len       <= '0;
      r_instr     <= '0;
      w           <= 1'b0;
      busy        <= 1'b0;
      finished    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      w        <= 1'b0;
      finished <= 1'b0;
      if (abort) begin
        r_state     <= S_IDLE;
        pc          <= '0;
        r_timer     <= '0;
        busy        <= 1'b0;
        err_timeout <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              if (prog_len == '0) begin
                // Empty program: report completion without ever looking busy.
                r_state  <= S_FINISH;
                finished <= 1'b1;
              end else begin
                r_len   <= (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
                pc      <= '0;
                busy    <= 1'b1;
                r_state <= S_FETCH;
              end
            end
          end
          S_FETCH: begin
            r_instr <= r_mem[pc];
            w       <= 1'b1;
            r_state <= S_ISSUE;
          end
          S_ISSUE: begin
            r_timer <= '0;
            r_state <= S_WAIT;
          end
          S_WAIT: begin
            if (done_in) begin
              if (w_last) begin
                finished <= 1'b1;
                r_state  <= S_FINISH;
              end else begin
                pc      <= pc + 1'b1;
                r_state <= S_FETCH;
              end
            end else if (r_timer == TIMER_MAX) begin
              busy        <= 1'b0;
              err_timeout <= 1'b1;
              r_state     <= S_ERR;
            end else begin
              r_timer <= r_timer + 1'b1;
            end
          end
          S_FINISH: begin
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end
          S_ERR: begin
            r_state <= S_ERR;
          end
          default: begin
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_proc_seq.sv
// Bench for proc_seq: directed programs, a behavioural processor answering Done,
// and a monitor that pops expected w/finished events from a queue.
module tb_proc_seq;

  localparam int DATA_W = 8;
  localparam int AW     = 4;
  localparam int IW     = 6 + DATA_W;
  localparam int W      = IW + 1;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd3;
  localparam logic [2:0] ST_ERR  = 3'd5;

  logic              clk;
  logic              rst;
  logic              prog_we;
  logic [AW-1:0]     prog_addr;
  logic [IW-1:0]     prog_wdata;
  logic [AW:0]       prog_len;
  logic              start;
  logic              abort;
  logic              done_in;
  logic              w;
  logic [1:0]        F, Rx, Ry;
  logic [DATA_W-1:0] din;
  logic              busy, finished, err_timeout;
  logic [AW-1:0]     pc;
  logic [2:0]        dbg_state;

  logic model_done, tb_done, model_on;
  assign done_in = model_done | tb_done;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];
  logic prev_w = 1'b0;

  localparam logic [IW-1:0] I0 = {2'b00, 2'b01, 2'b00, 8'h5A};
  localparam logic [IW-1:0] I1 = {2'b01, 2'b10, 2'b01, 8'h00};
  localparam logic [IW-1:0] I2 = {2'b10, 2'b01, 2'b10, 8'h00};
  localparam logic [IW-1:0] I3 = {2'b11, 2'b00, 2'b11, 8'h33};

  proc_seq #(.DATA_W(DATA_W), .DEPTH(16), .AW(AW), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_wdata(prog_wdata), .prog_len(prog_len), .start(start), .abort(abort),
    .done_in(done_in), .w(w), .F(F), .Rx(Rx), .Ry(Ry), .din(din), .busy(busy),
    .finished(finished), .err_timeout(err_timeout), .pc(pc), .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "time limit");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic prog(input logic [AW-1:0] a, input logic [IW-1:0] d);
    prog_we = 1'b1; prog_addr = a; prog_wdata = d;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic exp_w(input logic [IW-1:0] d);
    exp_q.push_back({1'b0, d});
  endtask

  task automatic exp_fin();
    exp_q.push_back({1'b1, {IW{1'b0}}});
  endtask

  task automatic wait_fin(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (finished) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic run(input logic [AW:0] len);
    prog_len = len; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // behavioural processor: Done 1 cycle after w for F=0x/1x? load/move, 3 for add/sub
  always @(negedge clk) begin
    if (w) begin
      int dly;
      dly = F[1] ? 3 : 1;
      repeat (dly) @(posedge clk);
      #1;
      if (model_on) model_done = 1'b1;
      @(posedge clk);
      #1 model_done = 1'b0;
    end
  end

  // scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (w) begin
      chk("w_single_cycle", {31'd0, prev_w}, 32'd0);
      chk("w_expected", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("w_instr", {17'd0, 1'b0, F, Rx, Ry, din}, {17'd0, e});
      end
    end
    if (finished) begin
      chk("fin_expected", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("fin_event", {17'd0, 1'b1, {IW{1'b0}}}, {17'd0, e});
      end
    end
    prev_w = w;
  end

  initial begin
    bit ok;
    int nw, sw, sf;
    rst = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_wdata = '0; prog_len = '0;
    start = 1'b0; abort = 1'b0; tb_done = 1'b0; model_done = 1'b0; model_on = 1'b1;

    // reset state
    tick(); tick();
    chk("reset_flags", {28'd0, w, busy, finished, err_timeout}, 32'd0);
    chk("reset_pc", {28'd0, pc}, 32'd0);
    chk("reset_instr", {18'd0, F, Rx, Ry, din}, 32'd0);
    chk("reset_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    rst = 1'b1;
    tick();
    prog(4'd0, I0); prog(4'd1, I1); prog(4'd2, I2); prog(4'd3, I3);

    // load program, 3 instructions
    exp_w(I0); exp_w(I1); exp_w(I2); exp_fin();
    run(5'd3);
    chk("t1_busy_fetch", {31'd0, busy}, 32'd1);
    tick();
    chk("t1_first_w_latency", {31'd0, w}, 32'd1);
    tick();
    chk("t1_w_dropped", {31'd0, w}, 32'd0);
    chk("t1_din_wait", {24'd0, din}, 32'h5A);
    wait_fin(ok);
    chk("t1_finished_seen", {31'd0, ok}, 32'd1);
    chk("t1_busy_at_fin", {31'd0, busy}, 32'd1);
    chk("t1_pc_last", {28'd0, pc}, 32'd2);
    tick();
    chk("t1_busy_after_fin", {30'd0, busy, finished}, 32'd0);

    // zero length
    exp_fin();
    run(5'd0);
    chk("t2_fin_pulse", {29'd0, finished, busy, w}, 32'd4);
    tick();
    chk("t2_after", {29'd0, finished, busy, w}, 32'd0);
    tick();

    // timeout
    model_on = 1'b0;
    exp_w(I0);
    run(5'd1);
    tick(); tick();
    repeat (7) tick();
    chk("t3_no_err_early", {30'd0, err_timeout, busy}, 32'd1);
    tick();
    chk("t3_err_set", {29'd0, err_timeout, busy, w}, 32'd4);
    chk("t3_state_err", {29'd0, dbg_state}, {29'd0, ST_ERR});
    repeat (3) tick();
    chk("t3_err_sticky", {31'd0, err_timeout}, 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t3_abort_idle", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    chk("t3_err_cleared", {31'd0, err_timeout}, 32'd0);
    model_on = 1'b1;
    repeat (4) tick();

    // abort mid-run, then restart
    exp_w(I0); exp_w(I1);
    run(5'd4);
    nw = 0;
    for (int i = 0; i < 60 && nw < 2; i++) begin
      tick();
      if (w) nw++;
    end
    chk("t4_second_w", nw, 32'd2);
    model_on = 1'b0;
    tick();
    chk("t4_in_wait", {29'd0, dbg_state}, {29'd0, ST_WAIT});
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t4_idle", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    chk("t4_pc_zero", {28'd0, pc}, 32'd0);
    chk("t4_not_busy", {31'd0, busy}, 32'd0);
    sw = 0; sf = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (w) sw++;
      if (finished) sf++;
    end
    chk("t4_no_stray_w", sw, 32'd0);
    chk("t4_no_stray_fin", sf, 32'd0);
    model_on = 1'b1;
    exp_w(I0); exp_w(I1); exp_w(I2); exp_w(I3); exp_fin();
    run(5'd4);
    wait_fin(ok);
    chk("t4_restart_fin", {31'd0, ok}, 32'd1);
    chk("t4_restart_pc", {28'd0, pc}, 32'd3);
    repeat (3) tick();

    // write lockout
    exp_w(I0); exp_fin();
    run(5'd1);
    prog(4'd0, {IW{1'b1}});
    wait_fin(ok);
    chk("t5_run_fin", {31'd0, ok}, 32'd1);
    repeat (2) tick();
    exp_w(I0); exp_fin();
    run(5'd1);
    wait_fin(ok);
    chk("t5_rerun_fin", {31'd0, ok}, 32'd1);
    repeat (2) tick();

    // stray Done in IDLE and ISSUE
    tb_done = 1'b1;
    tick();
    tb_done = 1'b0;
    chk("t5_idle_done_ignored", {28'd0, dbg_state, busy}, {28'd0, ST_IDLE, 1'b0});
    exp_w(I0); exp_fin();
    run(5'd1);
    tick();
    tb_done = 1'b1;
    tick();
    tb_done = 1'b0;
    chk("t5_issue_done_ignored", {28'd0, dbg_state, finished}, {28'd0, ST_WAIT, 1'b0});
    wait_fin(ok);
    chk("t5_issue_run_fin", {31'd0, ok}, 32'd1);
    repeat (3) tick();

    // reset mid-op
    model_on = 1'b0;
    exp_w(I0);
    run(5'd3);
    tick(); tick(); tick();
    rst = 1'b0;
    tick();
    chk("t6_reset_flags", {28'd0, w, busy, finished, err_timeout}, 32'd0);
    chk("t6_reset_regs", {14'd0, pc, F, Rx, Ry, din}, 32'd0);
    chk("t6_reset_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    rst = 1'b1;
    model_on = 1'b1;
    tick();
    exp_w(I0); exp_w(I1); exp_w(I2); exp_fin();
    run(5'd3);
    wait_fin(ok);
    chk("t6_rerun_fin", {31'd0, ok}, 32'd1);
    repeat (4) tick();

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
